// File: rtl/bus_drive_ctrl.sv
// Stream-to-bus feeder: FIFO-buffers upstream bytes, arbitrates via bus_req/bus_gnt and drives
// the registered drv_data/drv_en pair for the tristate stage. Optional feature: BUS_PARITY_EN.
module bus_drive_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  bus_req,
  input  logic                  bus_gnt,
  output logic [DATA_WIDTH-1:0] drv_data,
  output logic                  drv_en,
`ifdef BUS_PARITY_EN
  output logic                  drv_parity,
`endif
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t                state;
  logic [3:0]            turn_cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign s_ready    = !fifo_full;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];

  // A byte leaves the FIFO exactly when it is loaded onto drv_data.
  assign pop = bus_gnt && !fifo_empty && ((state == REQ) || (state == DRIVE));

  // NOTE: storage has no reset; only pointers and count need a known value, which keeps
  // the array mappable onto plain flops or a register file without reset wiring.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; a blocking '=' here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      turn_cnt   <= '0;
      bus_req    <= 1'b0;
      drv_en     <= 1'b0;
      drv_data   <= '0;
`ifdef BUS_PARITY_EN
      drv_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= REQ;
            bus_req <= 1'b1;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            state      <= DRIVE;
            drv_en     <= 1'b1;
            drv_data   <= head;
`ifdef BUS_PARITY_EN
            drv_parity <= ^head;
`endif
          end
        end
        DRIVE: begin
          // Emptiness is the pre-edge view, so a same-edge push ends the burst.
          if (bus_gnt && !fifo_empty) begin
            drv_data   <= head;
`ifdef BUS_PARITY_EN
            drv_parity <= ^head;
`endif
          end else begin
            state      <= TURN;
            drv_en     <= 1'b0;
            drv_data   <= '0;
            bus_req    <= 1'b0;
            turn_cnt   <= 4'(TURNAROUND - 1);
`ifdef BUS_PARITY_EN
            drv_parity <= 1'b0;
`endif
          end
        end
        TURN: begin
          if (turn_cnt == '0) state <= IDLE;
          else                turn_cnt <= turn_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_drive_ctrl.sv
// Scoreboard bench for bus_drive_ctrl: stimulus enqueues expected bytes, a negedge monitor
// pops and compares each driven byte; directed checks cover reset, latency, full and grant loss.
module tb_bus_drive_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] drv_data;
  logic       drv_en;
  logic       busy;
`ifdef BUS_PARITY_EN
  logic       drv_parity;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_seen   = 0;
  logic [7:0] exp_q[$];

  bus_drive_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TURNAROUND(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .drv_data (drv_data),
    .drv_en   (drv_en),
`ifdef BUS_PARITY_EN
    .drv_parity(drv_parity),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every driven byte must match the head of the scoreboard; idle bus must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (drv_en) begin
        if (exp_q.size() == 0) begin
          check("drive_with_empty_scoreboard", 32'(drv_en), 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          n_seen++;
          check("drv_data", 32'(drv_data), 32'(e));
`ifdef BUS_PARITY_EN
          check("drv_parity", 32'(drv_parity), 32'(^e));
`endif
        end
      end else begin
        check("idle_drv_data_zero", 32'(drv_data), 32'd0);
`ifdef BUS_PARITY_EN
        check("idle_parity_zero", 32'(drv_parity), 32'd0);
`endif
      end
    end
  end

  // Entered and left on a negedge.
  task automatic push_byte(input logic [7:0] d, input bit accept);
    s_valid = 1'b1;
    s_data  = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy && !drv_en) break;
      @(negedge clk);
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
    check({name, "_scoreboard_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_drive(input string name);
    for (int i = 0; i < 30; i++) begin
      if (drv_en) break;
      @(negedge clk);
    end
    check({name, "_drive_timeout"}, 32'(drv_en), 32'd1);
  endtask

  initial begin
    int n0;
    // 1: reset held with s_valid high
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h99;
    bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_drv_en", 32'(drv_en), 32'd0);
    check("rst_drv_data", 32'(drv_data), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // 2: two-byte burst with grant held, latency and turnaround
    s_valid = 1'b1;
    s_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    check("lat_req_after_edge0", 32'(bus_req), 32'd0);
    s_data = 8'h3C;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    s_valid = 1'b0;
    check("lat_req_after_edge1", 32'(bus_req), 32'd1);
    check("lat_en_after_edge1", 32'(drv_en), 32'd0);
    @(negedge clk);
    check("lat_en_after_edge2", 32'(drv_en), 32'd1);
    @(negedge clk);
    check("burst_second_byte_en", 32'(drv_en), 32'd1);
    @(negedge clk);
    check("turn_drv_en", 32'(drv_en), 32'd0);
    check("turn_bus_req", 32'(bus_req), 32'd0);
    check("turn_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("back_idle_busy", 32'(busy), 32'd0);
    check("back_idle_req", 32'(bus_req), 32'd0);

    // 3: fill with no grant, overflow byte dropped, then drain
    bus_gnt = 1'b0;
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    push_byte(8'h04, 1'b1);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_bus_req", 32'(bus_req), 32'd1);
    push_byte(8'hFF, 1'b0);
    check("full_still_full", 32'(s_ready), 32'd0);
    check("full_no_drive", 32'(drv_en), 32'd0);
    n0 = n_seen;
    bus_gnt = 1'b1;
    wait_idle("fill");
    check("fill_drained_count", 32'(n_seen - n0), 32'd4);

    // 4: grant dropped after first byte; remainder driven after re-request
    bus_gnt = 1'b0;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    n0 = n_seen;
    bus_gnt = 1'b1;
    wait_drive("gloss");
    check("gloss_first_byte", 32'(drv_data), 32'h11);
    bus_gnt = 1'b0;
    @(negedge clk);
    check("gloss_en_dropped", 32'(drv_en), 32'd0);
    check("gloss_req_dropped", 32'(bus_req), 32'd0);
    check("gloss_busy", 32'(busy), 32'd1);
    bus_gnt = 1'b1;
    wait_idle("gloss");
    check("gloss_total_count", 32'(n_seen - n0), 32'd3);

    // 5: asynchronous reset in the middle of a burst
    push_byte(8'h5A, 1'b1);
    push_byte(8'h6B, 1'b1);
    wait_drive("mid_rst");
    check("mid_rst_on_bus", 32'(drv_data), 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en_async", 32'(drv_en), 32'd0);
    check("mid_rst_data_async", 32'(drv_data), 32'd0);
    check("mid_rst_req_async", 32'(bus_req), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    check("mid_rst_fifo_empty", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("mid_rst_no_replay", 32'(drv_en), 32'd0);

    // 6: parity patterns (byte checks also exercise the data path without parity)
    push_byte(8'h07, 1'b1);
    push_byte(8'h03, 1'b1);
    wait_idle("parity");
`ifdef BUS_PARITY_EN
    check("parity_idle", 32'(drv_parity), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
